cp0_exception_seq: RTL and testbench
====================================

// Module: cp0_exception_seq
// PURPOSE
// Exception/interrupt sequencer that sits directly upstream of the CP0 register file.
// Owns the CP0 single write port and merges pipeline mtc0 writes with multi-cycle trap
// sequences that write EPC, Cause and Status. Implements eret, stalls the pipeline
// while sequencing, and issues a one-cycle PC redirect to the trap vector or to EPC.
// PARAMETERS
// N_INT        6             number of external interrupt lines (1..8), mapped to Cause.IP[N_INT-1:0]
// VECTOR_ADDR  32'h0000_0180 trap vector PC
// STATUS_ADDR  5'd12         CP0 Status index
// CAUSE_ADDR   5'd13         CP0 Cause index
// EPC_ADDR     5'd14         CP0 EPC index
// PORTS
// clk          in   1      clock, all state on posedge
// rst          in   1      asynchronous active-high reset
// int_req      in   N_INT  external interrupt lines, async level-sensitive
// exc_req      in   1      synchronous exception from pipeline (1-cycle pulse)
// exc_code     in   5      ExcCode for exc_req
// exc_pc       in   32     PC of faulting/interrupted instruction
// eret         in   1      eret instruction at commit (1-cycle pulse)
// mtc0_we      in   1      pipeline mtc0 write request
// mtc0_addr    in   5      mtc0 target register
// mtc0_data    in   32     mtc0 write data
// cp0_we       out  1      CP0 write enable
// cp0_waddr    out  5      CP0 write address
// cp0_wdata    out  32     CP0 write data
// stall        out  1      hold pipeline
// redirect     out  1      1-cycle PC redirect strobe
// redirect_pc  out  32     target PC, valid with redirect
// BEHAVIOUR
// - Reset: state IDLE; int_sync, status_sh, epc_sh, cap_pc, cap_code, cap_is_eret = 0; all outputs 0.
// - int_req through 2-flop synchroniser -> int_sync. Cause.IP = int_sync (no latching beyond sync).
// - Status shadow status_sh: bit0 IE, bit1 EXL, [15:8] IM. Updated on every cp0 write to STATUS_ADDR.
// - EPC shadow epc_sh updated on every cp0 write to EPC_ADDR.
// - int_take = status_sh[0] & ~status_sh[1] & |(int_sync & status_sh[8+:N_INT]).
// - States: IDLE, W_EPC, W_CAUSE, W_STATUS, W_ERET, REDIR.
// - IDLE, priority exc_req > int_take > eret > mtc0:
//   exc_req -> capture exc_pc, exc_code; go W_EPC. int_take -> capture exc_pc, code 0; go W_EPC.
//   eret -> go W_ERET. Otherwise mtc0 passes through combinationally (cp0_we=mtc0_we, same cycle).
//   When a trap or eret is accepted, a simultaneous mtc0 is dropped (no write).
// - W_EPC:    we=1, addr EPC_ADDR, data cap_pc -> W_CAUSE.
// - W_CAUSE:  we=1, addr CAUSE_ADDR, data {16'b0, IP(zero-ext to 8b), 1'b0, cap_code, 2'b0} -> W_STATUS.
// - W_STATUS: we=1, addr STATUS_ADDR, data status_sh with bit1 (EXL) = 1 -> REDIR (target VECTOR_ADDR).
// - W_ERET:   we=1, addr STATUS_ADDR, data status_sh with EXL = 0 -> REDIR (target epc_sh).
// - REDIR:    we=0, redirect=1 for exactly one cycle, redirect_pc per above -> IDLE.
// - stall = 1 in every state except IDLE; stall is 0 in the accepting IDLE cycle.
// - Latency: trap accepted cycle T; writes at T+1..T+3; redirect at T+4. eret: write T+1, redirect T+2.
// - Inputs exc_req/eret/mtc0 are ignored outside IDLE (pipeline is stalled and holds them).
// - Nested: EXL=1 masks interrupts; exc_req with EXL=1 still sequences (EPC overwritten).
// - rst mid-sequence: immediate return to IDLE, outputs 0, no partial write completes afterwards.
// TESTING
// 1 mtc0 IDLE: mtc0_we=1, addr 12, data 32'h0000_FF01 -> same cycle cp0_we=1/addr 12; status_sh=FF01.
// 2 exception: exc_req, code 5'd8, pc 32'h0040_0010 -> writes EPC=0040_0010, Cause=0000_0020,
//   Status=0000_FF03; redirect_pc 0000_0180 at T+4; stall high T+1..T+4.
// 3 interrupt: Status=FF01, int_req[2]=1 -> taken 3rd cycle after assert; Cause=0000_0400; EXL then masks.
// 4 eret: after test 3, eret -> Status=0000_FF01 at T+1, redirect to saved EPC at T+2.
// 5 collision: exc_req + eret + mtc0 same cycle -> exception sequence only, no mtc0 write.
// 6 reset at W_CAUSE -> next cycle cp0_we=0, stall=0, redirect never asserted.

Source files
------------

// File: rtl/cp0_exception_seq.sv
// CP0 exception/interrupt sequencer.
// Owns the single CP0 write port. It merges pipeline mtc0 writes with the
// EPC/Cause/Status trap sequence and the eret Status restore. It stalls the
// pipeline while it sequences and ends each sequence with a one-cycle PC redirect.
module cp0_exception_seq #(
    parameter int          N_INT       = 6,
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0180,
    parameter logic [4:0]  STATUS_ADDR = 5'd12,
    parameter logic [4:0]  CAUSE_ADDR  = 5'd13,
    parameter logic [4:0]  EPC_ADDR    = 5'd14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_INT-1:0] int_req,
    input  logic             exc_req,
    input  logic [4:0]       exc_code,
    input  logic [31:0]      exc_pc,
    input  logic             eret,
    input  logic             mtc0_we,
    input  logic [4:0]       mtc0_addr,
    input  logic [31:0]      mtc0_data,
    output logic             cp0_we,
    output logic [4:0]       cp0_waddr,
    output logic [31:0]      cp0_wdata,
    output logic             stall,
    output logic             redirect,
    output logic [31:0]      redirect_pc
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_EPC    = 3'd1,
        S_W_CAUSE  = 3'd2,
        S_W_STATUS = 3'd3,
        S_W_ERET   = 3'd4,
        S_REDIR    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [N_INT-1:0]   r_int_meta;
    logic [N_INT-1:0]   r_int_sync;
    logic [31:0]        r_status_sh;
    logic [31:0]        r_epc_sh;
    logic [31:0]        r_cap_pc;
    logic [4:0]         r_cap_code;
    logic               r_cap_is_eret;

    logic [7:0]         w_ip8;
    logic               w_idle;
    logic               w_int_take;
    logic               w_accept_trap;
    logic               w_accept_eret;

    // Cause.IP is the synchronised request level, zero-extended to eight bits.
    assign w_ip8         = 8'(r_int_sync);
    assign w_idle        = (r_state == S_IDLE);
    assign w_int_take    = r_status_sh[0] & ~r_status_sh[1]
                         & (|(r_int_sync & r_status_sh[8 +: N_INT]));
    assign w_accept_trap = w_idle & (exc_req | w_int_take);
    assign w_accept_eret = w_idle & ~exc_req & ~w_int_take & eret;

    // Two-flop synchroniser for the asynchronous interrupt lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int_meta <= '0;
            r_int_sync <= '0;
        end else begin
            r_int_meta <= int_req;
            r_int_sync <= r_int_meta;
        end
    end

    // Status and EPC shadows follow every write that leaves on the CP0 port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status_sh <= '0;
            r_epc_sh    <= '0;
        end else if (cp0_we) begin
            if (cp0_waddr == STATUS_ADDR) r_status_sh <= cp0_wdata;
            if (cp0_waddr == EPC_ADDR)    r_epc_sh    <= cp0_wdata;
        end
    end

    // Capture the trap context when a trap or eret is accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_pc      <= '0;
            r_cap_code    <= '0;
            r_cap_is_eret <= 1'b0;
        end else if (w_accept_trap) begin
            r_cap_pc      <= exc_pc;
            r_cap_code    <= exc_req ? exc_code : 5'd0;
            r_cap_is_eret <= 1'b0;
        end else if (w_accept_eret) begin
            r_cap_is_eret <= 1'b1;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state and write-port/stall/redirect outputs.
    always_comb begin
        w_next      = r_state;
        cp0_we      = 1'b0;
        cp0_waddr   = '0;
        cp0_wdata   = '0;
        stall       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        case (r_state)
            S_IDLE: begin
                stall = 1'b0;
                if (exc_req || w_int_take) begin
                    w_next = S_W_EPC;
                end else if (eret) begin
                    w_next = S_W_ERET;
                end else if (mtc0_we && !rst) begin
                    // Pipeline mtc0 reaches the register file in the same cycle.
                    cp0_we    = 1'b1;
                    cp0_waddr = mtc0_addr;
                    cp0_wdata = mtc0_data;
                end
            end
            S_W_EPC: begin
                cp0_we    = 1'b1;
                cp0_waddr = EPC_ADDR;
                cp0_wdata = r_cap_pc;
                w_next    = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                cp0_we    = 1'b1;
                cp0_waddr = CAUSE_ADDR;
                cp0_wdata = {16'h0000, w_ip8, 1'b0, r_cap_code, 2'b00};
                w_next    = S_W_STATUS;
            end
            S_W_STATUS: begin
                cp0_we    = 1'b1;
                cp0_waddr = STATUS_ADDR;
                cp0_wdata = r_status_sh | 32'h0000_0002;
                w_next    = S_REDIR;
            end
            S_W_ERET: begin
                cp0_we    = 1'b1;
                cp0_waddr = STATUS_ADDR;
                cp0_wdata = r_status_sh & ~32'h0000_0002;
                w_next    = S_REDIR;
            end
            S_REDIR: begin
                redirect    = 1'b1;
                redirect_pc = r_cap_is_eret ? r_epc_sh : VECTOR_ADDR;
                w_next      = S_IDLE;
            end
            default: begin
                stall  = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cp0_exception_seq.sv
// Testbench for cp0_exception_seq: directed scenarios followed by random
// traffic, every cycle checked against a transaction-level reference model.
module tb_cp0_exception_seq;

    localparam int N = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  int_req;
    logic          exc_req;
    logic [4:0]    exc_code;
    logic [31:0]   exc_pc;
    logic          eret;
    logic          mtc0_we;
    logic [4:0]    mtc0_addr;
    logic [31:0]   mtc0_data;
    logic          cp0_we;
    logic [4:0]    cp0_waddr;
    logic [31:0]   cp0_wdata;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;

    cp0_exception_seq #(.N_INT(N)) dut (
        .clk(clk), .rst(rst), .int_req(int_req), .exc_req(exc_req),
        .exc_code(exc_code), .exc_pc(exc_pc), .eret(eret),
        .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // Scheduled actions still owed by the sequencer after an accepted event.
    localparam int PH_EPC = 1, PH_CAUSE = 2, PH_STATUS = 3, PH_ERET = 4,
                   PH_RED_VEC = 5, PH_RED_EPC = 6;

    int          n_pass = 0;
    int          n_fail = 0;
    int          m_q[$];
    logic [31:0] m_status, m_epc, m_pc;
    logic [4:0]  m_code;
    logic [N-1:0] m_seen1, m_seen2;   // request levels one and two edges ago
    logic        o_we, o_stall, o_red;
    logic [4:0]  o_addr;
    logic [31:0] o_data, o_rpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_status = '0; m_epc = '0; m_pc = '0; m_code = '0;
        m_seen1 = '0; m_seen2 = '0;
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance.
    task automatic step();
        logic        e_we, e_red, take;
        logic [4:0]  e_addr;
        logic [31:0] e_data, e_rpc;
        int          ph;
        logic        busy;
        @(negedge clk);
        e_we = 1'b0; e_red = 1'b0; e_addr = '0; e_data = '0; e_rpc = '0;
        busy = (m_q.size() != 0);
        if (rst) begin
            model_reset();
            busy = 1'b0;
        end else if (!busy) begin
            take = m_status[0] && !m_status[1] && ((m_seen2 & m_status[8 +: N]) != 0);
            if (exc_req || take) begin
                m_pc   = exc_pc;
                m_code = exc_req ? exc_code : 5'd0;
                m_q    = '{PH_EPC, PH_CAUSE, PH_STATUS, PH_RED_VEC};
            end else if (eret) begin
                m_q = '{PH_ERET, PH_RED_EPC};
            end else if (mtc0_we) begin
                e_we = 1'b1; e_addr = mtc0_addr; e_data = mtc0_data;
            end
        end else begin
            ph = m_q.pop_front();
            case (ph)
                PH_EPC:     begin e_we = 1'b1; e_addr = 5'd14; e_data = m_pc; end
                PH_CAUSE:   begin
                    e_we = 1'b1; e_addr = 5'd13;
                    e_data = (32'(m_seen2) << 8) | (32'(m_code) << 2);
                end
                PH_STATUS:  begin e_we = 1'b1; e_addr = 5'd12; e_data = m_status | 32'h2; end
                PH_ERET:    begin e_we = 1'b1; e_addr = 5'd12; e_data = m_status & ~32'h2; end
                PH_RED_VEC: begin e_red = 1'b1; e_rpc = 32'h0000_0180; end
                default:    begin e_red = 1'b1; e_rpc = m_epc; end
            endcase
        end
        if (e_we && e_addr == 5'd12) m_status = e_data;
        if (e_we && e_addr == 5'd14) m_epc = e_data;
        o_we = cp0_we; o_addr = cp0_waddr; o_data = cp0_wdata;
        o_stall = stall; o_red = redirect; o_rpc = redirect_pc;
        chk("cp0_we", 32'(o_we), 32'(e_we));
        chk("cp0_waddr", 32'(o_addr), 32'(e_addr));
        chk("cp0_wdata", o_data, e_data);
        chk("stall", 32'(o_stall), 32'(busy));
        chk("redirect", 32'(o_red), 32'(e_red));
        chk("redirect_pc", o_rpc, e_rpc);
        @(posedge clk);
        if (rst) model_reset();
        else begin
            m_seen2 = m_seen1;
            m_seen1 = int_req;
        end
        #1;
    endtask

    task automatic idle_inputs();
        exc_req = 1'b0; eret = 1'b0; mtc0_we = 1'b0;
        mtc0_addr = '0; mtc0_data = '0; exc_code = '0; exc_pc = '0;
    endtask

    initial begin
        rst = 1'b1; int_req = '0;
        idle_inputs();
        model_reset();

        // Reset state
        step();
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_stall", 32'(o_stall), 32'd0);
        step();
        rst = 1'b0;

        // mtc0 pass-through in IDLE
        mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_data = 32'h0000_FF01;
        step();
        chk("t1_we", 32'(o_we), 32'd1);
        chk("t1_addr", 32'(o_addr), 32'd12);
        chk("t1_stall", 32'(o_stall), 32'd0);
        idle_inputs();

        // Synchronous exception
        exc_req = 1'b1; exc_code = 5'd8; exc_pc = 32'h0040_0010;
        step();
        chk("t2_acc_stall", 32'(o_stall), 32'd0);
        chk("t2_acc_we", 32'(o_we), 32'd0);
        idle_inputs();
        step(); chk("t2_epc", o_data, 32'h0040_0010); chk("t2_stall1", 32'(o_stall), 32'd1);
        step(); chk("t2_cause", o_data, 32'h0000_0020);
        step(); chk("t2_status", o_data, 32'h0000_FF03);
        step(); chk("t2_rpc", o_rpc, 32'h0000_0180); chk("t2_stall4", 32'(o_stall), 32'd1);
        step(); chk("t2_done", 32'(o_stall), 32'd0);

        // Interrupt through the synchroniser
        mtc0_we = 1'b1; mtc0_addr = 5'd12; mtc0_data = 32'h0000_FF01;
        step();
        idle_inputs();
        int_req = 6'b000100; exc_pc = 32'h0040_0020;
        step(); chk("t3_c0", 32'(o_stall), 32'd0);
        step(); chk("t3_c1", 32'(o_stall), 32'd0);
        step(); chk("t3_c2_we", 32'(o_we), 32'd0);
        step(); chk("t3_epc", o_data, 32'h0040_0020);
        step(); chk("t3_cause", o_data, 32'h0000_0400);
        step(); chk("t3_status", o_data, 32'h0000_FF03);
        step(); chk("t3_redir", 32'(o_red), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(); chk("t3_masked", 32'(o_stall), 32'd0);
        end

        // eret back to saved EPC
        int_req = '0;
        for (int i = 0; i < 3; i++) step();
        eret = 1'b1;
        step(); chk("t4_acc_we", 32'(o_we), 32'd0);
        eret = 1'b0;
        step(); chk("t4_status", o_data, 32'h0000_FF01); chk("t4_addr", 32'(o_addr), 32'd12);
        step(); chk("t4_rpc", o_rpc, 32'h0040_0020);

        // Collision of exception, eret and mtc0
        exc_req = 1'b1; eret = 1'b1; mtc0_we = 1'b1; mtc0_addr = 5'd14;
        mtc0_data = 32'hDEAD_BEEF; exc_code = 5'd4; exc_pc = 32'h0040_0030;
        step(); chk("t5_no_mtc0", 32'(o_we), 32'd0);
        idle_inputs();
        step(); chk("t5_epc", o_data, 32'h0040_0030);
        step(); chk("t5_cause", o_data, 32'h0000_0010);
        step();
        step(); chk("t5_rpc", o_rpc, 32'h0000_0180);

        // Reset in the Cause write
        exc_req = 1'b1; exc_code = 5'd1; exc_pc = 32'h0040_0040;
        step();
        idle_inputs();
        step();
        rst = 1'b1;
        step();
        chk("t6_we", 32'(o_we), 32'd0);
        chk("t6_stall", 32'(o_stall), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6_no_redir", 32'(o_red), 32'd0);
        end

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            exc_req  = (r == 0);
            eret     = (r == 1) || (r == 2);
            exc_code = 5'($urandom_range(0, 31));
            exc_pc   = $urandom;
            mtc0_we  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: mtc0_addr = 5'd12;
                1: mtc0_addr = 5'd13;
                2: mtc0_addr = 5'd14;
                default: mtc0_addr = 5'($urandom_range(0, 31));
            endcase
            mtc0_data = $urandom;
            if ($urandom_range(0, 7) == 0) int_req = N'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
